ctrl_pipe_unit: RTL and testbench

Pipelined successor to the combinational main decoder: decodes the ID-stage opcode into the control bundle and registers it into the ID/EX boundary. It owns load-use hazard detection, branch-flush bubbles and a parametrised multi-cycle multiply busy FSM. It sits between the IF/ID register and the EX stage, and drives the PC/IF-ID write enables.

---
 rtl/ctrl_pipe_unit.sv | 80 ++++++++
 tb/tb_ctrl_pipe_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: ID-stage decoder with ID/EX control register, load-use stall, branch flush and multi-cycle multiply hold
module ctrl_pipe_unit #(
  parameter int MUL_LAT    = 3,
  parameter bit ENABLE_MUL = 1'b1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [6:0]            Op_i,
  input  logic [6:0]            Funct7_i,
  input  logic [REG_ADDR_W-1:0] RS1addr_i,
  input  logic [REG_ADDR_W-1:0] RS2addr_i,
  input  logic [REG_ADDR_W-1:0] RDaddr_i,
  input  logic                  NoOp_i,
  input  logic                  Flush_i,
  output logic                  RegWrite_o,
  output logic                  MemReg_o,
  output logic                  MemRead_o,
  output logic                  MemWrite_o,
  output logic                  ALUSrc_o,
  output logic                  Branch_o,
  output logic                  MulOp_o,
  output logic [1:0]            ALUOp_o,
  output logic [REG_ADDR_W-1:0] RDaddr_o,
  output logic                  PCWrite_o,
  output logic                  IFIDWrite_o,
  output logic                  Stall_o,
  output logic                  MulBusy_o
);
  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BEQ = 7'b1100011;
  typedef enum logic {RUN, BUSY} state_t;
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [7:0]            r_ctl;
  logic                  r_mul;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [7:0]            w_dec;
  logic                  w_mul, w_uses_rs2, w_lu, w_busy, w_bubble;
  // bundle order: RegWrite, MemReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc, Branch
  assign w_dec = (Op_i == OP_R)   ? 8'b1000_1000 :
                 (Op_i == OP_I)   ? 8'b1000_0010 :
                 (Op_i == OP_LD)  ? 8'b1110_0010 :
                 (Op_i == OP_ST)  ? 8'b0001_0010 :
                 (Op_i == OP_BEQ) ? 8'b0000_0101 : 8'b0;
  assign w_mul      = ENABLE_MUL && (Op_i == OP_R) && (Funct7_i == 7'b0000001);
  assign w_uses_rs2 = (Op_i == OP_R) || (Op_i == OP_ST) || (Op_i == OP_BEQ);
  assign w_lu       = r_ctl[5] && (r_rd != '0) &&
                      ((r_rd == RS1addr_i) || (w_uses_rs2 && (r_rd == RS2addr_i)));
  assign w_busy     = (r_state == BUSY);
  assign w_bubble   = Flush_i || w_lu || NoOp_i;
  assign PCWrite_o   = !w_busy && (Flush_i || !w_lu);
  assign IFIDWrite_o = PCWrite_o;
  assign Stall_o     = !PCWrite_o;
  assign MulBusy_o   = w_busy;
  assign {RegWrite_o, MemReg_o, MemRead_o, MemWrite_o, ALUOp_o, ALUSrc_o, Branch_o} = r_ctl;
  assign MulOp_o  = r_mul;
  assign RDaddr_o = r_rd;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_ctl   <= '0;
      r_mul   <= 1'b0;
      r_rd    <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_state <= RUN;
    end else begin
      r_ctl <= w_bubble ? 8'b0 : w_dec;
      r_mul <= !w_bubble && w_mul;
      r_rd  <= w_bubble ? '0 : RDaddr_i;
      if (!w_bubble && w_mul && MUL_LAT > 1) begin
        r_state <= BUSY;
        r_cnt   <= CW'(MUL_LAT - 1);
      end
    end
  end
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb_ctrl_pipe_unit: directed tests over four parameter variants sharing one ID-stage stimulus
module tb_ctrl_pipe_unit;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BQ = 7'b1100011, BAD = 7'b1111111;
  localparam logic [6:0] F_MUL = 7'b0000001;
  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] op = 7'b0, f7 = 7'b0;
  logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic noop = 1'b0, flush = 1'b0;
  logic rw[4], mr[4], mrd[4], mw[4], asrc[4], br[4], mop[4], pcw[4], ifw[4], stl[4], bsy[4];
  logic [1:0] aop[4];
  logic [4:0] rdo[4];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  // d0: MUL_LAT=3, d1: MUL_LAT=4, d2: ENABLE_MUL=0, d3: MUL_LAT=1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    ctrl_pipe_unit #(.MUL_LAT(g == 0 ? 3 : g == 3 ? 1 : 4), .ENABLE_MUL(g != 2), .REG_ADDR_W(5)) u_dut (
      .clk_i(clk), .rst_i(rst), .Op_i(op), .Funct7_i(f7), .RS1addr_i(rs1), .RS2addr_i(rs2),
      .RDaddr_i(rd), .NoOp_i(noop), .Flush_i(flush), .RegWrite_o(rw[g]), .MemReg_o(mr[g]),
      .MemRead_o(mrd[g]), .MemWrite_o(mw[g]), .ALUSrc_o(asrc[g]), .Branch_o(br[g]),
      .MulOp_o(mop[g]), .ALUOp_o(aop[g]), .RDaddr_o(rdo[g]), .PCWrite_o(pcw[g]),
      .IFIDWrite_o(ifw[g]), .Stall_o(stl[g]), .MulBusy_o(bsy[g]));
  end
  function automatic logic [7:0] ctl(int i);
    return {rw[i], mr[i], mrd[i], mw[i], aop[i], asrc[i], br[i]};
  endfunction
  task automatic set_id(input logic [6:0] o, input logic [6:0] f, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d);
    op = o; f7 = f; rs1 = a; rs2 = b; rd = d;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    set_id(R, 7'b0, 5'd1, 5'd2, 5'd3);
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ctl(i) !== 8'b0 || mop[i] !== 1'b0 || rdo[i] !== 5'd0) begin failures++; $display("FAIL reset_regs d%0d got ctl=%b mul=%b rd=%0d want 0", i, ctl(i), mop[i], rdo[i]); end
      checks++; if (pcw[i] !== 1'b1 || ifw[i] !== 1'b1 || stl[i] !== 1'b0 || bsy[i] !== 1'b0) begin failures++; $display("FAIL reset_comb d%0d got pcw=%b ifw=%b stall=%b busy=%b want 1 1 0 0", i, pcw[i], ifw[i], stl[i], bsy[i]); end
    end
    rst = 1'b1;
  endtask
  task automatic test_opcode_sweep();
    logic [6:0] ops [6] = '{R, I, LD, ST, BQ, BAD};
    logic [7:0] exp [6] = '{8'b1000_1000, 8'b1000_0010, 8'b1110_0010, 8'b0001_0010, 8'b0000_0101, 8'b0};
    for (int k = 0; k < 6; k++) begin
      set_id(ops[k], 7'b0, 5'd0, 5'd0, 5'(k + 1));
      step();
      checks++; if (ctl(0) !== exp[k] || rdo[0] !== 5'(k + 1) || mop[0] !== 1'b0) begin failures++; $display("FAIL sweep op=%b got ctl=%b rd=%0d mul=%b want ctl=%b rd=%0d mul=0", ops[k], ctl(0), rdo[0], mop[0], exp[k], k + 1); end
    end
  endtask
  task automatic test_load_use();
    set_id(LD, 7'b0, 5'd1, 5'd0, 5'd5);
    step();
    set_id(R, 7'b0, 5'd2, 5'd5, 5'd6);
    #1;
    checks++; if (pcw[0] !== 1'b0 || ifw[0] !== 1'b0 || stl[0] !== 1'b1) begin failures++; $display("FAIL lu_stall got pcw=%b ifw=%b stall=%b want 0 0 1", pcw[0], ifw[0], stl[0]); end
    step();
    checks++; if (ctl(0) !== 8'b0 || rdo[0] !== 5'd0) begin failures++; $display("FAIL lu_bubble got ctl=%b rd=%0d want 0 0", ctl(0), rdo[0]); end
    checks++; if (pcw[0] !== 1'b1 || stl[0] !== 1'b0) begin failures++; $display("FAIL lu_release got pcw=%b stall=%b want 1 0", pcw[0], stl[0]); end
    step();
    checks++; if (ctl(0) !== 8'b1000_1000 || rdo[0] !== 5'd6) begin failures++; $display("FAIL lu_late_add got ctl=%b rd=%0d want 10001000 6", ctl(0), rdo[0]); end
    set_id(LD, 7'b0, 5'd1, 5'd0, 5'd0);
    step();
    set_id(R, 7'b0, 5'd0, 5'd0, 5'd6);
    #1;
    checks++; if (pcw[0] !== 1'b1 || stl[0] !== 1'b0) begin failures++; $display("FAIL lu_rd0 got pcw=%b stall=%b want 1 0", pcw[0], stl[0]); end
    set_id(LD, 7'b0, 5'd1, 5'd0, 5'd7);
    step();
    set_id(I, 7'b0, 5'd0, 5'd7, 5'd8);
    #1;
    checks++; if (pcw[0] !== 1'b1 || stl[0] !== 1'b0) begin failures++; $display("FAIL lu_itype_rs2 got pcw=%b stall=%b want 1 0", pcw[0], stl[0]); end
    set_id(ST, 7'b0, 5'd3, 5'd7, 5'd0);
    #1;
    checks++; if (pcw[0] !== 1'b0 || stl[0] !== 1'b1) begin failures++; $display("FAIL lu_store_rs2 got pcw=%b stall=%b want 0 1", pcw[0], stl[0]); end
    step();
  endtask
  task automatic test_flush_vs_lu();
    set_id(LD, 7'b0, 5'd1, 5'd0, 5'd5);
    step();
    set_id(R, 7'b0, 5'd5, 5'd2, 5'd6);
    flush = 1'b1;
    #1;
    checks++; if (pcw[0] !== 1'b1 || stl[0] !== 1'b0) begin failures++; $display("FAIL flush_lu_comb got pcw=%b stall=%b want 1 0", pcw[0], stl[0]); end
    step();
    flush = 1'b0;
    checks++; if (ctl(0) !== 8'b0 || rdo[0] !== 5'd0) begin failures++; $display("FAIL flush_bubble got ctl=%b rd=%0d want 0 0", ctl(0), rdo[0]); end
  endtask
  task automatic test_noop();
    set_id(R, 7'b0, 5'd1, 5'd2, 5'd9);
    noop = 1'b1;
    #1;
    checks++; if (pcw[0] !== 1'b1) begin failures++; $display("FAIL noop_pcw got %b want 1", pcw[0]); end
    step();
    noop = 1'b0;
    checks++; if (ctl(0) !== 8'b0 || rdo[0] !== 5'd0) begin failures++; $display("FAIL noop_bubble got ctl=%b rd=%0d want 0 0", ctl(0), rdo[0]); end
  endtask
  task automatic test_multiply();
    set_id(R, F_MUL, 5'd1, 5'd2, 5'd9);
    step();
    set_id(R, 7'b0, 5'd3, 5'd4, 5'd10);
    checks++; if (mop[2] !== 1'b0 || stl[2] !== 1'b0 || ctl(2) !== 8'b1000_1000 || rdo[2] !== 5'd9) begin failures++; $display("FAIL nomul_variant got mul=%b stall=%b ctl=%b rd=%0d want 0 0 10001000 9", mop[2], stl[2], ctl(2), rdo[2]); end
    checks++; if (mop[3] !== 1'b1 || stl[3] !== 1'b0 || bsy[3] !== 1'b0) begin failures++; $display("FAIL lat1_variant got mul=%b stall=%b busy=%b want 1 0 0", mop[3], stl[3], bsy[3]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (mop[1] !== 1'b1 || rdo[1] !== 5'd9) begin failures++; $display("FAIL mul_hold cyc%0d got mul=%b rd=%0d want 1 9", k, mop[1], rdo[1]); end
      checks++; if (bsy[1] !== (k < 3) || stl[1] !== (k < 3)) begin failures++; $display("FAIL mul_busy cyc%0d got busy=%b stall=%b want %0d", k, bsy[1], stl[1], k < 3); end
      if (k == 1) begin
        checks++; if (mop[3] !== 1'b0 || rdo[3] !== 5'd10) begin failures++; $display("FAIL lat1_next got mul=%b rd=%0d want 0 10", mop[3], rdo[3]); end
        flush = 1'b1;
      end
      step();
      flush = 1'b0;
    end
    checks++; if (mop[1] !== 1'b0 || ctl(1) !== 8'b1000_1000 || rdo[1] !== 5'd10 || bsy[1] !== 1'b0) begin failures++; $display("FAIL mul_then_add got mul=%b ctl=%b rd=%0d busy=%b want 0 10001000 10 0", mop[1], ctl(1), rdo[1], bsy[1]); end
  endtask
  task automatic test_back_to_back();
    set_id(R, F_MUL, 5'd1, 5'd2, 5'd11);
    step();
    set_id(R, F_MUL, 5'd1, 5'd2, 5'd12);
    repeat (3) step();
    checks++; if (bsy[1] !== 1'b0 || pcw[1] !== 1'b1 || rdo[1] !== 5'd11) begin failures++; $display("FAIL b2b_gap got busy=%b pcw=%b rd=%0d want 0 1 11", bsy[1], pcw[1], rdo[1]); end
    step();
    checks++; if (mop[1] !== 1'b1 || rdo[1] !== 5'd12 || bsy[1] !== 1'b1) begin failures++; $display("FAIL b2b_second got mul=%b rd=%0d busy=%b want 1 12 1", mop[1], rdo[1], bsy[1]); end
    set_id(I, 7'b0, 5'd0, 5'd0, 5'd0);
  endtask
  task automatic test_reset_mid_busy();
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    set_id(R, F_MUL, 5'd1, 5'd2, 5'd13);
    step();
    set_id(R, 7'b0, 5'd3, 5'd4, 5'd14);
    step();
    checks++; if (bsy[0] !== 1'b1 || mop[0] !== 1'b1) begin failures++; $display("FAIL rmb_busy got busy=%b mul=%b want 1 1", bsy[0], mop[0]); end
    rst = 1'b0;
    #1;
    checks++; if (ctl(0) !== 8'b0 || mop[0] !== 1'b0 || rdo[0] !== 5'd0 || bsy[0] !== 1'b0 || pcw[0] !== 1'b1) begin failures++; $display("FAIL rmb_abort got ctl=%b mul=%b rd=%0d busy=%b pcw=%b want 0 0 0 0 1", ctl(0), mop[0], rdo[0], bsy[0], pcw[0]); end
    rst = 1'b1;
    step();
    checks++; if (ctl(0) !== 8'b1000_1000 || mop[0] !== 1'b0 || rdo[0] !== 5'd14) begin failures++; $display("FAIL rmb_resume got ctl=%b mul=%b rd=%0d want 10001000 0 14", ctl(0), mop[0], rdo[0]); end
  endtask
  initial begin
    test_reset();
    test_opcode_sweep();
    test_load_use();
    test_flush_vs_lu();
    test_noop();
    test_multiply();
    test_back_to_back();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
